// File: rtl/rom_stream_reader_pkg.sv
// rom_stream_reader_pkg: state encoding and FIFO sizing shared by rom_stream_reader and its FIFO
package rom_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/rom_stream_reader_fifo.sv
// rom_stream_reader_fifo: 2-entry register FIFO holding {last, data}; entry 0 is always the head
//   clk, rst_n : clock, async active-low reset
//   push_i/din_i : write strobe and word; pop_i : remove head (only while non-empty)
//   count_o : occupancy 0..2; head_o : oldest entry (zero when empty after reset)
module rom_stream_reader_fifo
  import rom_stream_reader_pkg::*;
#(
  parameter int W = 9
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [1:0] count_q, count_d;
  logic wr_idx;
  // A simultaneous pop shifts entry 1 down, so the write slot moves one lower.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    wr_idx = pop_i ? count_q[1] : count_q[0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      count_q <= '0;
    end else begin
      if (pop_i) mem_q[0] <= mem_q[1];
      if (push_i) mem_q[wr_idx] <= din_i;
      count_q <= count_d;
    end
  end
  assign count_o = count_q;
  assign head_o = mem_q[0];
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks consecutive addresses of a sync-read ROM and streams the words out with backpressure
//   clk, rst_n : clock, async active-low reset
//   start/start_addr/start_len : transfer request, sampled only while idle
//   busy, done : transfer in progress, one-cycle completion pulse
//   mem_addr/mem_data : ROM address (sampled every edge) and read data (valid one cycle later)
//   out_data/out_valid/out_ready/out_last : output stream, out_last marks the final word
//   out_csum : XOR of words handshaked in the current transfer, only with ROM_STREAM_READER_CSUM_EN defined
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef ROM_STREAM_READER_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] out_csum
`endif
);
  state_e state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic busy_q, done_q, rd_pending_q, rd_last_q;
  logic [1:0] fifo_count, occ;
  logic pop, issue, drain_ok;
  assign pop = out_valid && out_ready;
  // Occupancy the FIFO will have once the in-flight read lands and this cycle's pop retires.
  assign occ = fifo_count + {1'b0, rd_pending_q} - {1'b0, pop};
  assign issue = (state_q == RUN) && (occ < 2'(FIFO_DEPTH));
  // Finish in the same cycle the final word leaves, so busy drops right after the last handshake.
  assign drain_ok = !rd_pending_q && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_pending_q <= issue;
      rd_last_q <= issue && cnt_q == LEN_WIDTH'(1);
      case (state_q)
        IDLE: if (start) begin
          addr_q <= start_addr;
          cnt_q <= start_len;
          state_q <= (start_len != '0) ? RUN : IDLE;
          busy_q <= start_len != '0;
          done_q <= start_len == '0;
        end
        RUN: if (issue) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          cnt_q <= cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) state_q <= DRAIN;
        end
        DRAIN: if (drain_ok) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  rom_stream_reader_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_pending_q),
    .pop_i   (pop),
    .din_i   ({rd_last_q, mem_data}),
    .count_o (fifo_count),
    .head_o  ({out_last, out_data})
  );
  assign out_valid = fifo_count != 2'd0;
  assign busy = busy_q;
  assign done = done_q;
  assign mem_addr = addr_q;
`ifdef ROM_STREAM_READER_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (pop) csum_q <= csum_q ^ out_data;
  end
  assign out_csum = csum_q;
`endif
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed vector bench for rom_stream_reader with an identity ROM model
module tb_rom_stream_reader;
  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic [7:0] start_addr, mem_addr, mem_data, out_data, rom_a;
  logic [8:0] start_len;
  logic busy, done, out_valid, out_last;
  logic [7:0] rom [256];
`ifdef ROM_STREAM_READER_CSUM_EN
  logic [7:0] out_csum;
`endif

  rom_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
`ifdef ROM_STREAM_READER_CSUM_EN
    ,
    .out_csum   (out_csum)
`endif
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_a <= mem_addr;
  assign mem_data = rom[rom_a];

  typedef struct {
    logic [7:0]  addr;
    logic [8:0]  len;
    logic [15:0] pat;
    int          mid;
    int          exp_fv;
    int          exp_done;
    logic [7:0]  exp_lastw;
    logic [7:0]  exp_csum;
  } vec_t;
  vec_t tv [8];

  int n_chk = 0, n_pass = 0;
  logic [7:0] got [$];
  int last_idx, last_n, first_v, done_n, done_cyc, hold_err, hs;
  logic busy0, busy_at_done;
  logic [7:0] csum_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run_xfer(input logic [7:0] a, input logic [8:0] l, input logic [15:0] pat, input int mid);
    logic prev_stall;
    logic [7:0] prev_data;
    got.delete();
    last_idx = -1; last_n = 0; first_v = -1; done_n = 0; done_cyc = -1;
    hold_err = 0; busy0 = 1'b0; busy_at_done = 1'b1; csum_done = 8'h00;
    prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    start = 1'b1; start_addr = a; start_len = l; out_ready = pat[0];
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = pat[c % 16];
      if (c == mid) begin
        start = 1'b1; start_addr = 8'h80; start_len = 9'd3;
      end else start = 1'b0;
      if (c == 0) busy0 = busy;
      if (prev_stall && (!out_valid || out_data != prev_data)) hold_err++;
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        if (out_last) begin
          last_idx = got.size();
          last_n++;
        end
        got.push_back(out_data);
      end
      if (done) begin
        done_n++;
        done_cyc = c;
        busy_at_done = busy;
`ifdef ROM_STREAM_READER_CSUM_EN
        csum_done = out_csum;
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    tv[0] = '{8'h02, 9'd5, 16'hFFFF, -1,  2,  7, 8'h06, 8'h06};
    tv[1] = '{8'h02, 9'd5, 16'h9999, -1,  2, -1, 8'h06, 8'h06};
    tv[2] = '{8'hFE, 9'd4, 16'hFFFF, -1,  2,  6, 8'h01, 8'h00};
    tv[3] = '{8'h00, 9'd0, 16'hFFFF, -1, -1,  0, 8'h00, 8'h00};
    tv[4] = '{8'h40, 9'd4, 16'hFFFF,  2,  2,  6, 8'h43, 8'h00};
    tv[5] = '{8'h01, 9'd3, 16'hFFFF, -1,  2,  5, 8'h03, 8'h00};
    tv[6] = '{8'h01, 9'd2, 16'hFFFF, -1,  2,  4, 8'h02, 8'h03};
    tv[7] = '{8'h30, 9'd3, 16'h5555, -1,  2, -1, 8'h32, 8'h33};
    rst_n = 1'b1; start = 1'b0; start_addr = 8'h00; start_len = 9'd0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_xfer(tv[v].addr, tv[v].len, tv[v].pat, tv[v].mid);
      chk($sformatf("v%0d_words", v), got.size(), int'(tv[v].len));
      for (int i = 0; i < got.size() && i < int'(tv[v].len); i++)
        chk($sformatf("v%0d_word%0d", v, i), got[i], int'(8'(tv[v].addr + 8'(i))));
      if (got.size() > 0) chk($sformatf("v%0d_lastword", v), got[got.size() - 1], tv[v].exp_lastw);
      chk($sformatf("v%0d_last_idx", v), last_idx, int'(tv[v].len) - 1);
      chk($sformatf("v%0d_last_n", v), last_n, (tv[v].len != 9'd0) ? 1 : 0);
      chk($sformatf("v%0d_first_valid", v), first_v, tv[v].exp_fv);
      chk($sformatf("v%0d_busy_start", v), busy0, (tv[v].len != 9'd0) ? 1 : 0);
      chk($sformatf("v%0d_done_n", v), done_n, 1);
      chk($sformatf("v%0d_busy_at_done", v), busy_at_done, 0);
      chk($sformatf("v%0d_hold_err", v), hold_err, 0);
      if (tv[v].exp_done >= 0) chk($sformatf("v%0d_done_cyc", v), done_cyc, tv[v].exp_done);
`ifdef ROM_STREAM_READER_CSUM_EN
      chk($sformatf("v%0d_csum", v), csum_done, tv[v].exp_csum);
`endif
    end

    @(negedge clk);
    start = 1'b1; start_addr = 8'h10; start_len = 9'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      if (out_valid) hs++;
      if (hs < 3) @(negedge clk);
    end
    chk("rst_mid_hs", hs, 3);
    chk("rst_mid_busy_before", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_last", out_last, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_done", done, 0);
    hs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || out_valid) hs++;
    end
    chk("rst_mid_quiet", hs, 0);
    rst_n = 1'b1;
    run_xfer(8'h00, 9'd2, 16'hFFFF, -1);
    chk("post_rst_words", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst_word0", got[0], 8'h00);
      chk("post_rst_word1", got[1], 8'h01);
    end
    chk("post_rst_last_idx", last_idx, 1);
    chk("post_rst_done_n", done_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
